// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard/forwarding controller.
// Scoreboard slot layout, forwarding select encoding and the slot liveness helper.
package hazard_pkg;

   localparam int unsigned RA_W  = 5;
   localparam int unsigned SLOTS = 3;

   typedef struct packed {
      logic            valid;
      logic [RA_W-1:0] rd;
      logic            wr;
      logic            load;
   } slot_t;

   typedef enum logic [1:0] {
      FWD_REG = 2'b00,
      FWD_MEM = 2'b01,
      FWD_WB  = 2'b10
   } fwd_sel_t;

   // A slot only produces hazards when it will really write a non-zero register
   function automatic logic slot_live(input slot_t s);
      return s.valid & s.wr & (s.rd != '0);
   endfunction

endpackage

// File: rtl/hazard_match.sv
// Comparator between one scoreboard slot and one source register.
// Reports a hit only for a live slot writing the (non-zero) source.
module hazard_match
   import hazard_pkg::*;
(
   input  slot_t           slot_i,
   input  logic [RA_W-1:0] src_i,
   output logic            hit_o
);

   assign hit_o = slot_live(slot_i) & (src_i != '0) & (slot_i.rd == src_i);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard, forwarding, ID bypass and branch-flush controller for the 5-stage core.
// Optional saturating stall/flush performance counters under HAZARD_PERF_EN.
module pipe_hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int unsigned REG_ADDR_W = RA_W
`ifdef HAZARD_PERF_EN
   ,
   parameter int unsigned CNT_W      = 32
`endif
)
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  id_valid,
   input  logic [REG_ADDR_W-1:0] id_rs1,
   input  logic [REG_ADDR_W-1:0] id_rs2,
   input  logic [REG_ADDR_W-1:0] id_rd,
   input  logic                  id_reg_write,
   input  logic                  id_mem_read,
   input  logic                  br_taken,
   output logic                  stall,
   output logic                  flush_ifid,
   output logic                  flush_idex,
   output logic                  flush_exmem,
   output logic [1:0]            fwd_a,
   output logic [1:0]            fwd_b,
   output logic                  byp_a,
   output logic                  byp_b
`ifdef HAZARD_PERF_EN
   ,
   output logic [CNT_W-1:0]      stall_cnt,
   output logic [CNT_W-1:0]      flush_cnt
`endif
);

   localparam int unsigned S_EX  = 0;
   localparam int unsigned S_MEM = 1;
   localparam int unsigned S_WB  = 2;
   localparam int unsigned N_CMP = 8;

   slot_t           sb_q [SLOTS];
   slot_t           sb_d [SLOTS];
   logic [RA_W-1:0] ex_rs1_q, ex_rs1_d;
   logic [RA_W-1:0] ex_rs2_q, ex_rs2_d;
   logic [RA_W-1:0] id_rs1_w, id_rs2_w;
   slot_t           id_slot;

   slot_t           cmp_slot [N_CMP];
   logic [RA_W-1:0] cmp_src  [N_CMP];
   logic [N_CMP-1:0] cmp_hit;

   logic            load_use_c;
   fwd_sel_t        fwd_a_sel, fwd_b_sel;

   assign id_rs1_w = RA_W'(id_rs1);
   assign id_rs2_w = RA_W'(id_rs2);

   // Comparator map: 0-1 load-use, 2-5 EX forwarding, 6-7 ID write-through
   always_comb begin
      cmp_slot[0] = sb_q[S_EX];  cmp_src[0] = id_rs1_w;
      cmp_slot[1] = sb_q[S_EX];  cmp_src[1] = id_rs2_w;
      cmp_slot[2] = sb_q[S_MEM]; cmp_src[2] = ex_rs1_q;
      cmp_slot[3] = sb_q[S_MEM]; cmp_src[3] = ex_rs2_q;
      cmp_slot[4] = sb_q[S_WB];  cmp_src[4] = ex_rs1_q;
      cmp_slot[5] = sb_q[S_WB];  cmp_src[5] = ex_rs2_q;
      cmp_slot[6] = sb_q[S_WB];  cmp_src[6] = id_rs1_w;
      cmp_slot[7] = sb_q[S_WB];  cmp_src[7] = id_rs2_w;
   end

   for (genvar g = 0; g < int'(N_CMP); g++) begin : g_match
      hazard_match u_match (
         .slot_i (cmp_slot[g]),
         .src_i  (cmp_src[g]),
         .hit_o  (cmp_hit[g])
      );
   end

   // A taken branch squashes the dependent instruction, so it never stalls
   assign load_use_c  = id_valid & sb_q[S_EX].load & (cmp_hit[0] | cmp_hit[1]);
   assign stall       = load_use_c & ~br_taken;
   assign flush_ifid  = br_taken;
   assign flush_idex  = br_taken;
   assign flush_exmem = br_taken;
   assign byp_a       = id_valid & cmp_hit[6];
   assign byp_b       = id_valid & cmp_hit[7];

   // Loads in MEM have no ALU result yet, so they are never forwarded from MEM
   always_comb begin
      fwd_a_sel = FWD_REG;
      fwd_b_sel = FWD_REG;
      if (cmp_hit[2] & ~sb_q[S_MEM].load) begin
         fwd_a_sel = FWD_MEM;
      end else if (cmp_hit[4]) begin
         fwd_a_sel = FWD_WB;
      end
      if (cmp_hit[3] & ~sb_q[S_MEM].load) begin
         fwd_b_sel = FWD_MEM;
      end else if (cmp_hit[5]) begin
         fwd_b_sel = FWD_WB;
      end
   end

   assign fwd_a = fwd_a_sel;
   assign fwd_b = fwd_b_sel;

   // Scoreboard shift with bubble insertion on stall and flush
   always_comb begin
      id_slot.valid = id_valid;
      id_slot.rd    = RA_W'(id_rd);
      id_slot.wr    = id_reg_write;
      id_slot.load  = id_mem_read;

      sb_d[S_WB]  = sb_q[S_MEM];
      sb_d[S_MEM] = br_taken ? slot_t'('0) : sb_q[S_EX];
      sb_d[S_EX]  = (br_taken | stall) ? slot_t'('0) : id_slot;
      ex_rs1_d    = stall ? '0 : id_rs1_w;
      ex_rs2_d    = stall ? '0 : id_rs2_w;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(SLOTS); i++) begin
            sb_q[i] <= '0;
         end
         ex_rs1_q <= '0;
         ex_rs2_q <= '0;
      end else begin
         for (int i = 0; i < int'(SLOTS); i++) begin
            sb_q[i] <= sb_d[i];
         end
         ex_rs1_q <= ex_rs1_d;
         ex_rs2_q <= ex_rs2_d;
      end
   end

`ifdef HAZARD_PERF_EN
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   // Saturating event counters
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (stall && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
      if (br_taken && (flush_cnt_q != '1)) begin
         flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed pipeline scenarios then random traffic,
// checked against an instruction-level model of the EX/MEM/WB pipeline.
module tb_pipe_hazard_ctrl;

   localparam int RW = 5;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          id_valid = 1'b0;
   logic [RW-1:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
   logic          id_reg_write = 1'b0, id_mem_read = 1'b0, br_taken = 1'b0;
   logic          stall, flush_ifid, flush_idex, flush_exmem, byp_a, byp_b;
   logic [1:0]    fwd_a, fwd_b;
`ifdef HAZARD_PERF_EN
   logic [31:0]   stall_cnt, flush_cnt;
`endif

   always #5 clk = ~clk;

   pipe_hazard_ctrl dut (
      .clk          (clk),
      .rst          (rst),
      .id_valid     (id_valid),
      .id_rs1       (id_rs1),
      .id_rs2       (id_rs2),
      .id_rd        (id_rd),
      .id_reg_write (id_reg_write),
      .id_mem_read  (id_mem_read),
      .br_taken     (br_taken),
      .stall        (stall),
      .flush_ifid   (flush_ifid),
      .flush_idex   (flush_idex),
      .flush_exmem  (flush_exmem),
      .fwd_a        (fwd_a),
      .fwd_b        (fwd_b),
      .byp_a        (byp_a),
      .byp_b        (byp_b)
`ifdef HAZARD_PERF_EN
      ,
      .stall_cnt    (stall_cnt),
      .flush_cnt    (flush_cnt)
`endif
   );

   typedef struct {
      bit v;
      int rd;
      bit wr;
      bit ld;
   } instr_t;

   typedef struct {
      bit      stall;
      bit      flush;
      int      fwd_a;
      int      fwd_b;
      bit      byp_a;
      bit      byp_b;
      longint  scnt;
      longint  fcnt;
   } exp_t;

   // Model: pipe[0]=EX, pipe[1]=MEM, pipe[2]=WB
   instr_t  pipe[$];
   int      m_rs1, m_rs2;
   longint  m_scnt, m_fcnt;
   exp_t    sbq[$];
   exp_t    mon_e;
   int      n_err = 0;
   int      n_chk = 0;

   localparam longint CNT_MAX = 64'h0000_0000_FFFF_FFFF;

   function automatic instr_t bubble();
      instr_t b;
      b.v = 0; b.rd = 0; b.wr = 0; b.ld = 0;
      return b;
   endfunction

   function automatic bit live(input instr_t i);
      return i.v && i.wr && (i.rd != 0);
   endfunction

   function automatic int fwd_of(input int src);
      if (live(pipe[1]) && !pipe[1].ld && pipe[1].rd == src) return 2'b01;
      if (live(pipe[2]) && pipe[2].rd == src) return 2'b10;
      return 2'b00;
   endfunction

   task automatic chk(input string name, input longint act, input longint exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one ID-stage cycle, record its expected response, advance the model
   task automatic step(input bit v, input int rs1, input int rs2, input int rd,
                       input bit rw, input bit ml, input bit br, input bit r);
      exp_t   e;
      bit     hz;
      instr_t ni, nm;
      @(posedge clk);
      #1;
      id_valid = v; id_rs1 = RW'(rs1); id_rs2 = RW'(rs2); id_rd = RW'(rd);
      id_reg_write = rw; id_mem_read = ml; br_taken = br; rst = r;

      hz = v && live(pipe[0]) && pipe[0].ld &&
           ((rs1 != 0 && rs1 == pipe[0].rd) || (rs2 != 0 && rs2 == pipe[0].rd));
      e.stall = hz && !br;
      e.flush = br;
      e.fwd_a = fwd_of(m_rs1);
      e.fwd_b = fwd_of(m_rs2);
      e.byp_a = v && live(pipe[2]) && pipe[2].rd == rs1;
      e.byp_b = v && live(pipe[2]) && pipe[2].rd == rs2;
      e.scnt  = m_scnt;
      e.fcnt  = m_fcnt;
      sbq.push_back(e);

      if (r) begin
         pipe = '{bubble(), bubble(), bubble()};
         m_rs1 = 0; m_rs2 = 0; m_scnt = 0; m_fcnt = 0;
      end else begin
         ni.v = v; ni.rd = rd; ni.wr = rw; ni.ld = ml;
         if (br || e.stall) ni = bubble();
         nm = br ? bubble() : pipe[0];
         void'(pipe.pop_back());
         pipe[0] = nm;
         pipe.push_front(ni);
         m_rs1 = e.stall ? 0 : rs1;
         m_rs2 = e.stall ? 0 : rs2;
         if (e.stall && m_scnt != CNT_MAX) m_scnt++;
         if (br && m_fcnt != CNT_MAX) m_fcnt++;
      end
   endtask

   task automatic idle();
      step(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   // Monitor: every cycle presents a response; compare against the oldest expectation
   always @(negedge clk) begin
      if (sbq.size() != 0) begin
         mon_e = sbq.pop_front();
         chk("stall", stall, mon_e.stall);
         chk("flush_ifid", flush_ifid, mon_e.flush);
         chk("flush_idex", flush_idex, mon_e.flush);
         chk("flush_exmem", flush_exmem, mon_e.flush);
         chk("fwd_a", fwd_a, mon_e.fwd_a);
         chk("fwd_b", fwd_b, mon_e.fwd_b);
         chk("byp_a", byp_a, mon_e.byp_a);
         chk("byp_b", byp_b, mon_e.byp_b);
`ifdef HAZARD_PERF_EN
         chk("stall_cnt", stall_cnt, mon_e.scnt);
         chk("flush_cnt", flush_cnt, mon_e.fcnt);
`endif
      end
   end

   initial begin
      pipe = '{bubble(), bubble(), bubble()};
      m_rs1 = 0; m_rs2 = 0; m_scnt = 0; m_fcnt = 0;

      step(0, 0, 0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 0, 0, 1);
      idle();
      @(negedge clk);
      chk("reset_stall", stall, 0);
      chk("reset_fwd_a", fwd_a, 0);

      // ld x5 ; add x6,x5,x2 (held one cycle by the stall)
      step(1, 1, 0, 5, 1, 1, 0, 0);
      step(1, 5, 2, 6, 1, 0, 0, 0);
      @(negedge clk); chk("lu_stall", stall, 1);
      step(1, 5, 2, 6, 1, 0, 0, 0);
      @(negedge clk); chk("lu_release", stall, 0);
      idle();
      @(negedge clk); chk("lu_fwd_wb", fwd_a, 2);
      idle(); idle();

      // add x6,x1,x2 ; sub x7,x6,x6
      step(1, 1, 2, 6, 1, 0, 0, 0);
      step(1, 6, 6, 7, 1, 0, 0, 0);
      idle();
      @(negedge clk); chk("mem_fwd_a", fwd_a, 1); chk("mem_fwd_b", fwd_b, 1);
      idle(); idle();

      // MEM and WB both write x6: MEM wins
      step(1, 1, 2, 6, 1, 0, 0, 0);
      step(1, 3, 4, 6, 1, 0, 0, 0);
      step(1, 6, 0, 7, 1, 0, 0, 0);
      idle();
      @(negedge clk); chk("prio_fwd_a", fwd_a, 1);
      // Same with rd = x0 never forwards
      step(1, 1, 2, 0, 1, 0, 0, 0);
      step(1, 3, 4, 0, 1, 0, 0, 0);
      step(1, 0, 0, 7, 1, 0, 0, 0);
      idle();
      @(negedge clk); chk("x0_fwd_a", fwd_a, 0); chk("x0_fwd_b", fwd_b, 0);

      // WB writes x9 while ID reads x9 as rs2
      step(1, 1, 2, 9, 1, 0, 0, 0);
      idle(); idle();
      step(1, 3, 9, 10, 1, 0, 0, 0);
      @(negedge clk); chk("byp_b", byp_b, 1); chk("byp_a_clr", byp_a, 0);
      idle(); idle();

      // Taken branch together with a load-use hazard
      step(1, 1, 0, 5, 1, 1, 0, 0);
      step(1, 5, 0, 6, 1, 0, 1, 0);
      @(negedge clk);
      chk("br_stall", stall, 0);
      chk("br_flush_ifid", flush_ifid, 1);
      chk("br_flush_idex", flush_idex, 1);
      chk("br_flush_exmem", flush_exmem, 1);
      idle();
      step(1, 5, 0, 0, 0, 0, 0, 0);
      @(negedge clk); chk("br_squashed_load", byp_a, 0);

      // Reset with three live slots in flight
      step(1, 0, 0, 1, 1, 0, 0, 0);
      step(1, 0, 0, 2, 1, 0, 0, 0);
      step(1, 0, 0, 3, 1, 0, 0, 0);
      step(1, 1, 2, 4, 1, 1, 1, 1);
      step(1, 1, 2, 0, 0, 0, 0, 0);
      @(negedge clk);
      chk("rst_stall", stall, 0);
      chk("rst_fwd_a", fwd_a, 0);
      chk("rst_byp_a", byp_a, 0);
      chk("rst_byp_b", byp_b, 0);
`ifdef HAZARD_PERF_EN
      chk("rst_stall_cnt", stall_cnt, 0);
      chk("rst_flush_cnt", flush_cnt, 0);
`endif

      // Two stalls and one flush after reset
      step(1, 1, 0, 5, 1, 1, 0, 0);
      step(1, 5, 0, 6, 1, 0, 0, 0);
      step(1, 5, 0, 6, 1, 0, 0, 0);
      step(1, 1, 0, 5, 1, 1, 0, 0);
      step(1, 0, 5, 7, 1, 0, 0, 0);
      step(1, 0, 5, 7, 1, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 1, 0);
      idle();
`ifdef HAZARD_PERF_EN
      @(negedge clk);
      chk("perf_stall_cnt", stall_cnt, 2);
      chk("perf_flush_cnt", flush_cnt, 1);
`endif

      // Random traffic over a small register window to force frequent hits
      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(0, 7) != 0,
              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 3)),
              $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
              $urandom_range(0, 9) == 0, $urandom_range(0, 63) == 0);
      end
      idle();
      @(negedge clk);
      #1;
      chk("scoreboard_drain", sbq.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Parametrised hazard, forwarding and flush controller for the 5-stage pipelined RISC-V core. It keeps a shift-register scoreboard of in-flight register writes across EX, MEM and WB. From it the block produces the load-use stall, the EX-operand forwarding selects, the ID-stage write-through bypass and the branch flush. The core uses these to drive its IF/ID, ID/EX and EX/MEM buffers and operand muxes, which removes the need for NOP padding in software.

## Interface
- REG_ADDR_W, default 5: register address width; register 0 is hardwired zero and never matches.
- CNT_W, default 32: width of the performance counters (used only with HAZARD_PERF_EN).
- clk  input  1  core clock.
- rst  input  1  reset: synchronous to clk, active-high. Clears all slots and counters.
- id_valid  input  1  ID stage holds a real instruction.
- id_rs1, id_rs2  input  REG_ADDR_W  ID source registers.
- id_rd  input  REG_ADDR_W  ID destination register.
- id_reg_write  input  1  ID instruction writes rd.
- id_mem_read  input  1  ID instruction is a load.
- br_taken  input  1  branch resolved taken in MEM (zero & branch).
- stall  output  1  hold PC and IF/ID; insert a bubble into ID/EX.
- flush_ifid, flush_idex, flush_exmem  output  1  zero the valid/control bits of the named buffer.
- fwd_a, fwd_b  output  2  EX operand select: 00 ID/EX register value, 01 EX/MEM ALU result, 10 WB write data.
- byp_a, byp_b  output  1  ID read port must take WB write data instead of the register file.
- stall_cnt, flush_cnt  output  CNT_W  performance counters (present only with HAZARD_PERF_EN).

## Operation
- Scoreboard slots S_EX, S_MEM and S_WB each hold {valid, rd, wr, load}. An entry is "live" when valid & wr & rd != 0.
- Every cycle the slots shift: S_WB <= S_MEM, S_MEM <= S_EX, S_EX <= {id_valid, id_rd, id_reg_write, id_mem_read}.
- The block also registers id_rs1 and id_rs2 into ex_rs1 and ex_rs2 on the same edge.
- Load-use: stall = id_valid & S_EX live & S_EX.load & (id_rs1 == S_EX.rd | id_rs2 == S_EX.rd), with matches on register 0 excluded.
  - On a stall, S_EX loads a bubble (valid = 0) and ex_rs1/ex_rs2 load 0.
  - S_MEM and S_WB still shift.
- Forwarding, evaluated per operand:
  - fwd = 01 if S_MEM is live, not a load, and its rd equals the EX source register.
  - Otherwise fwd = 10 if S_WB is live and its rd matches.
  - Otherwise fwd = 00.
  - MEM has priority over WB.
- Bypass: byp_a = id_valid & S_WB live & S_WB.rd == id_rs1, excluding register 0. byp_b is the same with id_rs2.
- Branch: when br_taken = 1, flush_ifid, flush_idex and flush_exmem are all asserted combinationally in the same cycle.
  - S_EX and S_MEM load bubbles on the next edge.
  - S_WB shifts normally, because the branch itself writes nothing.
- Simultaneous br_taken and load-use hazard: flush wins and stall is forced to 0.
- A stall and a bubble in S_EX never block the shift of older slots.

## Timing
- stall, flush_*, fwd_* and byp_* are combinational from the current slots and inputs, so they are valid in the same cycle.
- Scoreboard update latency is one clock edge.
- A load-use hazard costs exactly one stall cycle: on the following cycle S_EX holds the bubble, the load is in S_MEM, and stall deasserts.
- A taken branch costs three bubbles and no stall.
- Reset values: every slot invalid, ex_rs1 = ex_rs2 = 0, stall = 0, flush_* = 0, fwd_a = fwd_b = 00, byp_a = byp_b = 0, counters = 0.
- Reset mid-operation clears all in-flight slots on the next edge. rst dominates br_taken and stall.
- Counters saturate at all-ones and never wrap.

## Configuration
- HAZARD_PERF_EN defined:
  - stall_cnt increments on every cycle with stall = 1.
  - flush_cnt increments on every cycle with br_taken = 1.
  - Both counters are synchronously cleared by rst.
- HAZARD_PERF_EN undefined: the counter ports and logic are removed entirely, and the rest of the behaviour is identical.

## Structure
- Package hazard_pkg holds:
  - typedef slot_t (struct: valid, rd, wr, load).
  - enum fwd_sel_t {FWD_REG = 2'b00, FWD_MEM = 2'b01, FWD_WB = 2'b10}.
  - localparam SLOTS = 3.
- One sub-module, hazard_match: a combinational comparator taking a slot_t and a source register and returning hit, with the register-0 and live qualification built in. It is instantiated per slot and operand.

## Test plan
- `ld x5,0(x1)` followed by `add x6,x5,x2`: stall = 1 for exactly one cycle. The next cycle has S_EX bubble and fwd_a = 10 when the add reaches EX (the load is then in WB).
- `add x6,x1,x2` then `sub x7,x6,x6`: no stall, and fwd_a = fwd_b = 01 in the sub's EX cycle.
- S_MEM and S_WB both write x6 while EX reads x6: fwd_a = 01 (MEM priority). With rd = x0 in both slots, fwd_a = 00.
- WB writing x9 while ID reads x9 as rs2: byp_b = 1 and byp_a = 0.
- br_taken in the same cycle as a load-use hazard: all three flush_* = 1 and stall = 0. The next cycle S_EX and S_MEM are invalid.
- Assert rst mid-stream with three live slots: the next cycle all outputs are 0 and the counters are 0. With HAZARD_PERF_EN, two stalls and one flush after reset give stall_cnt = 2 and flush_cnt = 1.
